// File: rtl/fpmul_out_collector.sv
// Output collector for the pipelined FP multiplier: latency-matched valid pipe,
// result FIFO, saturating result counter and 32-bit MISR signature.
module fpmul_out_collector #(
   parameter int LATENCY = 4,
   parameter int DEPTH   = 8
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        CLR,
   input  logic        VIN,
   input  logic [31:0] FP_Z,
   input  logic        RD_EN,
   output logic [31:0] DOUT,
   output logic        DOUT_VLD,
   output logic        FULL,
   output logic        EMPTY,
   output logic        OVF,
   output logic [15:0] CNT,
   output logic [31:0] SIG
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

   function automatic logic [31:0] misr_next(input logic [31:0] sig, input logic [31:0] din);
      misr_next = {sig[30:0], sig[31] ^ sig[21] ^ sig[1] ^ sig[0]} ^ din;
   endfunction

   logic [LATENCY-1:0] vpipe_q, vpipe_d;
   logic [LATENCY:0]   vshift_s;
   logic [AW-1:0]      wr_q, wr_d, rd_q, rd_d;
   logic [AW:0]        count_q, count_d;
   logic [31:0]        dout_q, dout_d;
   logic               dvld_q, dvld_d;
   logic               ovf_q, ovf_d;
   logic [15:0]        cnt_q, cnt_d;
   logic [31:0]        sig_q, sig_d;
   logic [31:0]        mem_q [DEPTH];
   logic               cap_s, pop_s, push_s, full_s, empty_s;

   assign full_s   = (count_q == DEPTH_C);
   assign empty_s  = (count_q == '0);
   assign cap_s    = vpipe_q[LATENCY-1];
   // Empty FIFO never pops, so a concurrent push is stored, not bypassed.
   assign pop_s    = RD_EN & ~empty_s & ~CLR;
   assign push_s   = cap_s & (~full_s | pop_s) & ~CLR;
   assign vshift_s = {vpipe_q, VIN};

   always_comb begin
      vpipe_d = vshift_s[LATENCY-1:0];
      wr_d    = wr_q;
      rd_d    = rd_q;
      count_d = count_q;
      dout_d  = dout_q;
      dvld_d  = 1'b0;
      ovf_d   = ovf_q;
      cnt_d   = cnt_q;
      sig_d   = sig_q;
      if (CLR) begin
         vpipe_d = '0;
         wr_d    = '0;
         rd_d    = '0;
         count_d = '0;
         dout_d  = 32'h0000_0000;
         ovf_d   = 1'b0;
         cnt_d   = 16'h0000;
         sig_d   = 32'h0000_0000;
      end else begin
         if (pop_s) begin
            dout_d = mem_q[rd_q];
            dvld_d = 1'b1;
            rd_d   = rd_q + 1'b1;
         end else begin
            dout_d = dout_q;
         end
         if (push_s) begin
            wr_d = wr_q + 1'b1;
         end else begin
            wr_d = wr_q;
         end
         case ({push_s, pop_s})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
         endcase
         // Dropped words still advance CNT and SIG so the signature covers every result.
         if (cap_s) begin
            ovf_d = ovf_q | ~push_s;
            cnt_d = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'h0001;
            sig_d = misr_next(sig_q, FP_Z);
         end else begin
            ovf_d = ovf_q;
         end
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         vpipe_q <= '0;
         wr_q    <= '0;
         rd_q    <= '0;
         count_q <= '0;
         dout_q  <= 32'h0000_0000;
         dvld_q  <= 1'b0;
         ovf_q   <= 1'b0;
         cnt_q   <= 16'h0000;
         sig_q   <= 32'h0000_0000;
      end else begin
         vpipe_q <= vpipe_d;
         wr_q    <= wr_d;
         rd_q    <= rd_d;
         count_q <= count_d;
         dout_q  <= dout_d;
         dvld_q  <= dvld_d;
         ovf_q   <= ovf_d;
         cnt_q   <= cnt_d;
         sig_q   <= sig_d;
      end
   end

   // Storage array needs no reset; occupancy gates every read.
   always_ff @(posedge CLK) begin
      if (push_s) begin
         mem_q[wr_q] <= FP_Z;
      end
   end

   assign DOUT     = dout_q;
   assign DOUT_VLD = dvld_q;
   assign FULL     = full_s;
   assign EMPTY    = empty_s;
   assign OVF      = ovf_q;
   assign CNT      = cnt_q;
   assign SIG      = sig_q;
endmodule
